// File: rtl/reg_sweep_writer_if.sv
// -----------------------------------------------------------------------------
// reg_sweep_writer_if
//   Control/status bundle between a sweep controller (master) and the
//   reg_sweep_writer sequencer (slave).
//
//   Master -> slave : go, direction, start, count, stall, abort
//   Slave -> master : regnum, wr_en, busy, done, finish
//
//   ADDR_W : width of the register index (regfile has 2**ADDR_W entries).
// -----------------------------------------------------------------------------
interface reg_sweep_writer_if #(
  parameter int ADDR_W = 5
);
  logic              go;
  logic              direction;
  logic [ADDR_W-1:0] start;
  logic [ADDR_W:0]   count;
  logic              stall;
  logic              abort;
  logic [ADDR_W-1:0] regnum;
  logic              wr_en;
  logic              busy;
  logic              done;
  logic              finish;

  modport master (
    output go, direction, start, count, stall, abort,
    input  regnum, wr_en, busy, done, finish
  );

  modport slave (
    input  go, direction, start, count, stall, abort,
    output regnum, wr_en, busy, done, finish
  );
endinterface

// File: rtl/reg_sweep_writer.sv
// -----------------------------------------------------------------------------
// reg_sweep_writer
//   Generates a register-index stream and write enable for a regfile write
//   port. A sweep starts at any index, runs for a programmable number of
//   writes, steps up or down with modulo wrap, and can be stalled or aborted.
//   Write data is supplied outside this block.
//
//   clock : system clock, rising edge
//   reset : asynchronous, active-low
//   bus   : reg_sweep_writer_if slave modport
//           in : go, direction, start, count (0..2**ADDR_W), stall, abort
//           out: regnum, wr_en, busy, done (= ~busy), finish (1-cycle pulse)
// -----------------------------------------------------------------------------
module reg_sweep_writer #(
  parameter int ADDR_W = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  reg_sweep_writer_if.slave     bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state_q,     state_d;
  logic [ADDR_W-1:0] regnum_q,    regnum_d;
  logic [ADDR_W:0]   remaining_q, remaining_d;
  logic              dir_q,       dir_d;
  logic              finish_q,    finish_d;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      regnum_q    <= '0;
      remaining_q <= '0;
      dir_q       <= 1'b0;
      finish_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      regnum_q    <= regnum_d;
      remaining_q <= remaining_d;
      dir_q       <= dir_d;
      finish_q    <= finish_d;
    end
  end

  // NOTE: every variable gets a default before the case statement so no path
  // leaves a value unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    regnum_d    = regnum_q;
    remaining_d = remaining_q;
    dir_d       = dir_q;
    finish_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        // abort and stall have no meaning here; regnum keeps its last value.
        if (bus.go) begin
          if (bus.count != '0) begin
            state_d     = RUN;
            regnum_d    = bus.start;
            remaining_d = bus.count;
            dir_d       = bus.direction;
          end else begin
            // Empty sweep completes at once: pulse finish, never write.
            finish_d = 1'b1;
          end
        end
      end

      RUN: begin
        if (bus.abort) begin
          // Abort wins over stall and over the final write; no finish pulse.
          state_d     = IDLE;
          remaining_d = '0;
        end else if (bus.stall) begin
          // Hold index and count; wr_en is already suppressed.
        end else if (remaining_q == ONE) begin
          // Last write is being presented now; regnum stays on that index.
          state_d     = IDLE;
          remaining_d = '0;
          finish_d    = 1'b1;
        end else begin
          // Natural ADDR_W-bit overflow gives the modulo 2**ADDR_W wrap.
          regnum_d    = dir_q ? regnum_q + 1'b1 : regnum_q - 1'b1;
          remaining_d = remaining_q - ONE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // wr_en is combinational so a stall or abort suppresses the write in the
  // same cycle it is raised.
  assign bus.wr_en  = (state_q == RUN) & ~bus.stall & ~bus.abort;
  assign bus.busy   = (state_q == RUN);
  assign bus.done   = (state_q != RUN);
  assign bus.finish = finish_q;
  assign bus.regnum = regnum_q;

endmodule

// File: doc/reg_sweep_writer.md
Name: reg_sweep_writer

Overview:
Parametrised successor to the fixed 32-register sweep writer. It sequences a register-number stream for a regfile write port and drives the write enable. Sweeps start at any index, run for a programmable count, go up or down with modulo wrap, and support a stall input and an abort. It sits between control logic and the regfile's write-address and write-enable inputs; the write data comes from outside the block.

Parameters:
ADDR_W, 5, width of the register index; the regfile has 2**ADDR_W entries.

Ports:
clock  in  1  single system clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-low; 0 forces the reset state immediately.
go  in  1  start request; sampled only in IDLE.
direction  in  1  0 = descending index, 1 = ascending index; latched on an accepted go.
start  in  ADDR_W  first register index; latched on an accepted go.
count  in  ADDR_W+1  number of writes, 0..2**ADDR_W; latched on an accepted go.
stall  in  1  hold the current index and suppress the write this cycle.
abort  in  1  terminate the sweep early.
regnum  out  ADDR_W  current register index for the regfile write address.
wr_en  out  1  regfile write enable.
busy  out  1  1 while in RUN.
done  out  1  0 while in RUN, 1 otherwise; keeps the legacy "~done = writing" meaning when stall is 0.
finish  out  1  one-cycle pulse when a sweep completes normally.

Behaviour:
- Reset state: IDLE, regnum=0, busy=0, done=1, finish=0, wr_en=0, internal remaining=0, latched dir=0.
- wr_en is combinational: (state==RUN) & ~stall & ~abort. It is therefore 0 asynchronously while reset=0.
- States: IDLE and RUN only.

IDLE:
- go=1 and count!=0 → RUN at the next edge, with regnum=start, remaining=count, dir=direction latched.
- go=1 and count==0 → stay in IDLE; finish=1 for one cycle; no write.
- abort and stall are ignored in IDLE; regnum holds its last value.

RUN, on each rising edge:
- abort=1 → IDLE; finish stays 0; regnum holds. Abort overrides stall and the final write.
- else stall=1 → hold regnum and remaining; no write occurs that cycle.
- else remaining==1 → IDLE; finish=1 for the following cycle; regnum holds the last index written.
- else regnum = regnum+1 (dir=1) or regnum-1 (dir=0), modulo 2**ADDR_W; remaining -= 1.

Other rules:
- Latency: go accepted at edge k → first write presented in cycle k..k+1. A sweep of N writes with no stalls occupies exactly N cycles of busy=1. finish is high in the cycle after the last write.
- go, start, count and direction changes during RUN are ignored.
- Wrap-around: ascending from 2**ADDR_W-1 goes to 0; descending from 0 goes to 2**ADDR_W-1. count=2**ADDR_W writes every register exactly once.
- Back-to-back sweeps: go may be asserted in the finish cycle; the new sweep starts at the next edge.
- Reset asserted mid-sweep: immediate IDLE with all outputs at reset values. No further writes; no finish pulse.
- finish is registered and cleared at the next edge, or immediately by reset.

Test Plan:
- ADDR_W=5, start=0, count=32, dir=1, go for 1 cycle → regnum 0,1,...,31 over 32 cycles with wr_en=1 and done=0 throughout; one finish pulse; regfile holds the data stream in r0..r31.
- start=2, count=5, dir=0 → regnum 2,1,0,31,30 with wrap; exactly 5 wr_en cycles; finish pulse.
- start=10, count=4, dir=1, stall high for 2 cycles at index 11 → regnum holds at 11 with wr_en=0 for 2 cycles; writes 10,11,12,13; busy lasts 6 cycles.
- start=5, count=8, abort in the 3rd RUN cycle → writes only at 5 and 6; wr_en=0 in the abort cycle; IDLE next; no finish pulse.
- Drive reset=0 mid-sweep, between clock edges → wr_en, busy and regnum drop to 0 and done rises to 1 without waiting for a clock edge.
- go with count=0 → finish pulse, no wr_en. Then go asserted in the finish cycle of a count=1 sweep → second sweep starts at the next edge with no idle gap.
